// File: rtl/rom_load_router.sv
// rom_load_router: steers an ioctl ROM download stream into NREG address
// regions. It also counts the bytes per region to flag complete regions, and
// captures the DIP-switch and mod-byte side streams.
// Optional feature: define ROM_LOAD_ROUTER_CHECKSUM_EN to add rom_sum, the
// 16-bit running sum of routed bytes.
module rom_load_router #(
  parameter int                 NREG     = 3,
  parameter int                 AW       = 16,
  parameter logic [NREG*25-1:0] REG_BASE = {25'h0FF00, 25'h0E000, 25'h00000},
  parameter logic [NREG*25-1:0] REG_SIZE = {25'h10000, 25'h01000, 25'h08000}
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ioctl_download,
  input  logic            ioctl_wr,
  input  logic [7:0]      ioctl_index,
  input  logic [24:0]     ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic [NREG-1:0] rom_wr,
  output logic [AW-1:0]   rom_addr,
  output logic [7:0]      rom_data,
  output logic [NREG-1:0] region_ok,
  output logic            load_done,
  output logic [63:0]     dip_sw,
  output logic [7:0]      mod_byte,
  output logic            mod_valid
`ifdef ROM_LOAD_ROUTER_CHECKSUM_EN
  ,
  output logic [15:0]     rom_sum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t          state_q, state_d;
  logic            load_entry;
  logic            route_en;
  logic            hit;
  logic [NREG-1:0] match;
  logic [NREG-1:0] sel;
  logic [24:0]     offs [NREG];
  logic [AW-1:0]   addr_sel;

  logic [NREG-1:0] rom_wr_q;
  logic [AW-1:0]   rom_addr_q;
  logic [7:0]      rom_data_q;
  logic [63:0]     dip_sw_q;
  logic [7:0]      mod_byte_q;
  logic            mod_valid_q;

  // A ROM download starts on the first cycle that shows download with index 0.
  // That entry cycle both clears the bookkeeping and routes its own byte.
  assign load_entry = (state_q == IDLE) && ioctl_download && (ioctl_index == 8'd0);
  assign route_en   = ioctl_wr && (ioctl_index == 8'd0) && (load_entry || (state_q == LOAD));
  assign hit        = route_en && (|match);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_region
      localparam logic [25:0] LO   = {1'b0, REG_BASE[gi*25 +: 25]};
      localparam logic [24:0] SIZE = REG_SIZE[gi*25 +: 25];

      logic [25:0] diff;
      logic [24:0] cnt_q;
      logic        ok_q;

      // If the address is below the base, the subtraction wraps and sets bit 25.
      // Otherwise the low bits are the region-relative offset.
      assign diff      = {1'b0, ioctl_addr} - LO;
      assign match[gi] = !diff[25] && (diff[24:0] < SIZE);
      assign offs[gi]  = diff[24:0];
      assign region_ok[gi] = ok_q;

      // Per-region byte counter: restarts at download entry and saturates at all-ones.
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          cnt_q <= '0;
        end else if (load_entry) begin
          cnt_q <= (route_en && sel[gi]) ? 25'd1 : 25'd0;
        end else if (route_en && sel[gi] && (cnt_q != '1)) begin
          cnt_q <= cnt_q + 25'd1;
        end
      end

      // Completeness flag: cleared at entry and evaluated once during DONE.
      always_ff @(posedge clk_sys) begin
        if (reset || load_entry) begin
          ok_q <= 1'b0;
        end else if (state_q == DONE) begin
          ok_q <= (cnt_q == SIZE);
        end
      end
    end
  endgenerate

  // Priority select: scanning from the top down leaves the lowest-numbered match.
  always_comb begin
    sel      = '0;
    addr_sel = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel      = '0;
        sel[i]   = 1'b1;
        addr_sel = offs[i][AW-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state. load_done is high for exactly the single DONE cycle.
  always_comb begin
    state_d   = state_q;
    load_done = 1'b0;
    case (state_q)
      IDLE:    if (load_entry) state_d = LOAD;
      LOAD:    if (!ioctl_download) state_d = DONE;
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Routed write port, registered one cycle after the ioctl strobe.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_wr_q   <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
    end else begin
      rom_wr_q <= route_en ? sel : '0;
      if (hit) begin
        rom_addr_q <= addr_sel;
        rom_data_q <= ioctl_dout;
      end
    end
  end

  // Side-stream capture of DIP bytes and the mod byte, active in every state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dip_sw_q    <= '0;
      mod_byte_q  <= '0;
      mod_valid_q <= 1'b0;
    end else begin
      if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0)) begin
        dip_sw_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
      if (ioctl_wr && (ioctl_index == 8'd1)) begin
        mod_byte_q  <= ioctl_dout;
        mod_valid_q <= 1'b1;
      end
    end
  end

`ifdef ROM_LOAD_ROUTER_CHECKSUM_EN
  logic [15:0] sum_q;

  // Running sum of routed bytes. It restarts at download entry and holds between downloads.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q <= '0;
    end else if (load_entry) begin
      sum_q <= hit ? {8'd0, ioctl_dout} : 16'd0;
    end else if (hit) begin
      sum_q <= sum_q + {8'd0, ioctl_dout};
    end
  end

  assign rom_sum = sum_q;
`endif

  assign rom_wr    = rom_wr_q;
  assign rom_addr  = rom_addr_q;
  assign rom_data  = rom_data_q;
  assign dip_sw    = dip_sw_q;
  assign mod_byte  = mod_byte_q;
  assign mod_valid = mod_valid_q;

endmodule

// File: tb/tb_rom_load_router.sv
// tb_rom_load_router: randomized and directed stimulus for rom_load_router.
// Outputs are compared every cycle against a behavioural model built from
// the region map. Region 3 overlaps region 1, so the priority rule is exercised.
module tb_rom_load_router;
  localparam int NREG = 4;
  localparam int AW   = 16;
  localparam logic [NREG*25-1:0] P_BASE = {25'h0E800, 25'h0FF00, 25'h0E000, 25'h00000};
  localparam logic [NREG*25-1:0] P_SIZE = {25'h00100, 25'h00200, 25'h01000, 25'h01000};

  int base_a [NREG] = '{32'h0000, 32'hE000, 32'hFF00, 32'hE800};
  int size_a [NREG] = '{32'h1000, 32'h1000, 32'h0200, 32'h0100};

  logic            clk_sys = 1'b0;
  logic            reset = 1'b1;
  logic            ioctl_download = 1'b0;
  logic            ioctl_wr = 1'b0;
  logic [7:0]      ioctl_index = 8'd0;
  logic [24:0]     ioctl_addr = '0;
  logic [7:0]      ioctl_dout = '0;
  logic [NREG-1:0] rom_wr;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_data;
  logic [NREG-1:0] region_ok;
  logic            load_done;
  logic [63:0]     dip_sw;
  logic [7:0]      mod_byte;
  logic            mod_valid;
`ifdef ROM_LOAD_ROUTER_CHECKSUM_EN
  logic [15:0]     rom_sum;
`endif

  rom_load_router #(.NREG(NREG), .AW(AW), .REG_BASE(P_BASE), .REG_SIZE(P_SIZE)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .rom_wr(rom_wr), .rom_addr(rom_addr),
    .rom_data(rom_data), .region_ok(region_ok), .load_done(load_done),
    .dip_sw(dip_sw), .mod_byte(mod_byte), .mod_valid(mod_valid)
`ifdef ROM_LOAD_ROUTER_CHECKSUM_EN
    , .rom_sum(rom_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state. phase is 0 = idle, 1 = loading, 2 = finishing.
  int              phase;
  int              cnt [NREG];
  logic [NREG-1:0] m_ok;
  logic [63:0]     m_dip;
  logic [7:0]      m_mod;
  logic            m_modv;
  logic [15:0]     m_sum;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int region_of(input logic [24:0] addr);
    for (int i = 0; i < NREG; i++) begin
      if (int'(addr) >= base_a[i] && int'(addr) < base_a[i] + size_a[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    phase  = 0;
    m_ok   = '0;
    m_dip  = '0;
    m_mod  = '0;
    m_modv = 1'b0;
    m_sum  = '0;
    for (int i = 0; i < NREG; i++) cnt[i] = 0;
  endtask

  // Drive one cycle, advance the model, then compare the registered outputs.
  task automatic cycle(input bit dl, input bit wr, input logic [7:0] idx,
                       input logic [24:0] addr, input logic [7:0] d);
    bit              accept;
    int              r;
    logic [NREG-1:0] e_wr;
    logic [AW-1:0]   e_addr;
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_index    = idx;
    ioctl_addr     = addr;
    ioctl_dout     = d;
    accept = wr && (idx == 8'd0) && (phase == 1 || (phase == 0 && dl));
    if (phase == 0 && dl && idx == 8'd0) begin
      for (int i = 0; i < NREG; i++) cnt[i] = 0;
      m_ok  = '0;
      m_sum = '0;
    end
    if (phase == 2) begin
      for (int i = 0; i < NREG; i++) m_ok[i] = (cnt[i] == size_a[i]);
    end
    r      = accept ? region_of(addr) : -1;
    e_wr   = '0;
    e_addr = '0;
    if (r >= 0) begin
      e_wr[r] = 1'b1;
      e_addr  = 16'(int'(addr) - base_a[r]);
      if (cnt[r] < 32'h1FFFFFF) cnt[r]++;
      m_sum = m_sum + 16'(d);
    end
    if (wr && idx == 8'd254 && addr < 25'd8) m_dip[addr[2:0]*8 +: 8] = d;
    if (wr && idx == 8'd1) begin
      m_mod  = d;
      m_modv = 1'b1;
    end
    if (phase == 0)      phase = (dl && idx == 8'd0) ? 1 : 0;
    else if (phase == 1) phase = dl ? 1 : 2;
    else                 phase = 0;
    @(posedge clk_sys);
    #1;
    check("rom_wr", rom_wr, e_wr);
    if (r >= 0) begin
      check("rom_addr", rom_addr, e_addr);
      check("rom_data", rom_data, d);
    end
    check("load_done", load_done, (phase == 2));
    check("region_ok", region_ok, m_ok);
    check("dip_sw", dip_sw, m_dip);
    check("mod_byte", mod_byte, m_mod);
    check("mod_valid", mod_valid, m_modv);
`ifdef ROM_LOAD_ROUTER_CHECKSUM_EN
    check("rom_sum", rom_sum, m_sum);
`endif
    $display("cyc dl=%0d wr=%0d idx=%0d addr=%h d=%h -> rom_wr=%b ok=%b done=%0d",
             dl, wr, idx, addr, d, rom_wr, region_ok, load_done);
  endtask

  task automatic do_reset();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    reset          = 1'b1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    model_clear();
    check("rst_rom_wr", rom_wr, '0);
    check("rst_rom_addr", rom_addr, '0);
    check("rst_rom_data", rom_data, '0);
    check("rst_region_ok", region_ok, '0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_dip_sw", dip_sw, '0);
    check("rst_mod_byte", mod_byte, '0);
    check("rst_mod_valid", mod_valid, 1'b0);
`ifdef ROM_LOAD_ROUTER_CHECKSUM_EN
    check("rst_rom_sum", rom_sum, '0);
`endif
    $display("reset applied");
  endtask

  // Writes every byte of regions 0..2, with side-stream cycles mixed in.
  // If short0 is set, the last byte of region 0 is skipped and a stray
  // write to an unmapped address is added instead.
  task automatic full_download(input bit short0);
    cycle(1'b1, 1'b1, 8'd0, 25'd0, 8'($urandom));
    for (int r = 0; r < 3; r++) begin
      for (int a = base_a[r]; a < base_a[r] + size_a[r]; a++) begin
        if (a == 0) continue;
        if (short0 && a == size_a[0] - 1) begin
          cycle(1'b1, 1'b1, 8'd0, 25'h09000, 8'h5A);
          continue;
        end
        if ($urandom % 8 == 0) begin
          cycle(1'b1, 1'($urandom), ($urandom % 2) ? 8'd1 : 8'd254,
                25'($urandom_range(0, 12)), 8'($urandom));
        end
        cycle(1'b1, 1'b1, 8'd0, 25'(a), 8'($urandom));
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
  endtask

  initial begin
    logic [63:0] dip_prev;
    int          k;
    logic [24:0] addr;
    logic [7:0]  idx;

    do_reset();

    // DIP and mod capture while idle.
    cycle(1'b0, 1'b1, 8'd254, 25'd2, 8'h3C);
    check("dip_byte2", dip_sw[23:16], 8'h3C);
    dip_prev = dip_sw;
    cycle(1'b0, 1'b1, 8'd254, 25'd8, 8'hFF);
    check("dip_addr8_ignored", dip_sw, dip_prev);
    cycle(1'b0, 1'b1, 8'd1, 25'd0, 8'h04);
    check("mod_byte_dir", mod_byte, 8'h04);
    check("mod_valid_dir", mod_valid, 1'b1);

    // Complete download of every non-overlapped region.
    full_download(1'b0);
    check("ok_full", region_ok, 4'b0111);

    // Entry-cycle write into region 1.
    cycle(1'b1, 1'b1, 8'd0, 25'h0E123, 8'hA5);
    check("e123_wr", rom_wr, 4'b0010);
    check("e123_addr", rom_addr, 16'h0123);
    check("e123_data", rom_data, 8'hA5);

    // Random traffic, including region boundaries and index changes mid-load.
    repeat (1500) begin
      k = $urandom % 3;
      if (k == 0) begin
        addr = 25'($urandom_range(0, 32'h11FFF));
      end else if (k == 1) begin
        k = $urandom % NREG;
        case ($urandom % 4)
          0:       addr = 25'(base_a[k] - 1);
          1:       addr = 25'(base_a[k]);
          2:       addr = 25'(base_a[k] + size_a[k] - 1);
          default: addr = 25'(base_a[k] + size_a[k]);
        endcase
      end else begin
        addr = 25'($urandom_range(0, 15));
      end
      case ($urandom % 6)
        0, 1, 2: idx = 8'd0;
        3:       idx = 8'd1;
        4:       idx = 8'd254;
        default: idx = 8'd7;
      endcase
      cycle(($urandom % 40) != 0, ($urandom % 4) != 0, idx, addr, 8'($urandom));
    end
    repeat (3) cycle(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);

    // Region 0 one byte short, with an unmapped write.
    full_download(1'b1);
    check("ok_short0", region_ok, 4'b0110);

    // Reset in the middle of a download aborts it.
    cycle(1'b1, 1'b1, 8'd0, 25'd0, 8'h11);
    for (int i = 1; i < 20; i++) cycle(1'b1, 1'b1, 8'd0, 25'(i), 8'($urandom));
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
    check("abort_ok", region_ok, 4'b0000);
    full_download(1'b0);
    check("ok_after_abort", region_ok, 4'b0111);

`ifdef ROM_LOAD_ROUTER_CHECKSUM_EN
    cycle(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
    cycle(1'b1, 1'b1, 8'd0, 25'd5, 8'hFF);
    cycle(1'b1, 1'b1, 8'd0, 25'd6, 8'h02);
    cycle(1'b1, 1'b1, 8'd0, 25'd7, 8'h01);
    check("sum_0102", rom_sum, 16'h0102);
    repeat (3) cycle(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
    check("sum_hold", rom_sum, 16'h0102);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_load_router.md
ROM_LOAD_ROUTER -- requirements
Module: rom_load_router

Interface
REQ-001 Parameter NREG, default 3: number of ROM regions, legal range 1..8.
REQ-002 Parameter AW, default 16: width of region-relative write address.
REQ-003 Parameter REG_BASE, default {25'h0FF00, 25'h0E000, 25'h00000}: packed NREG x 25-bit region base addresses; region 0 occupies the LSBs.
REQ-004 Parameter REG_SIZE, default {25'h10000, 25'h01000, 25'h08000}: packed NREG x 25-bit region byte sizes, each nonzero and no larger than 2^AW.
REQ-005 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ioctl_download  in  1  download window active.
REQ-008 ioctl_wr  in  1  one-cycle byte write strobe.
REQ-009 ioctl_index  in  8  stream type: 0 = ROM, 1 = mod byte, 254 = DIP.
REQ-010 ioctl_addr  in  25  stream byte address.
REQ-011 ioctl_dout  in  8  stream byte.
REQ-012 rom_wr  out  NREG  one-hot per-region write strobe.
REQ-013 rom_addr  out  AW  ioctl_addr minus the base of the selected region.
REQ-014 rom_data  out  8  byte accompanying rom_wr.
REQ-015 region_ok  out  NREG  region received exactly REG_SIZE bytes in the last ROM download.
REQ-016 load_done  out  1  one-cycle pulse at the end of a ROM download.
REQ-017 dip_sw  out  64  eight DIP bytes; byte n at bits [8n+7:8n].
REQ-018 mod_byte  out  8  last mod byte received.
REQ-019 mod_valid  out  1  set once a mod byte has been received.

Function
REQ-020 FSM states: IDLE, LOAD, DONE.
REQ-021 IDLE -> LOAD when ioctl_download=1 and ioctl_index=0; on that entry cycle, clear all per-region byte counters and region_ok.
REQ-022 LOAD -> DONE when ioctl_download=0; DONE -> IDLE unconditionally after one cycle, with load_done=1 only during DONE.
REQ-023 In DONE, region_ok[i] is set to (counter[i]==REG_SIZE[i]).
REQ-024 In LOAD, a byte is routed when ioctl_wr=1 and ioctl_index=0; it goes to region i if REG_BASE[i] <= ioctl_addr < REG_BASE[i]+REG_SIZE[i].
REQ-025 Overlapping regions: the lowest-numbered match wins; rom_wr stays one-hot or zero.
REQ-026 An address matching no region is dropped: rom_wr=0 and no counter changes.
REQ-027 Latency is exactly one cycle: rom_wr, rom_addr and rom_data are registered from the write cycle; rom_wr is 0 on every other cycle.
REQ-028 Per-region counters are 25-bit and saturate at all-ones; a byte re-sent to the same address is counted again.
REQ-029 The ioctl_index=0 write on the IDLE->LOAD entry cycle itself is routed.
REQ-030 DIP capture, in any state: if ioctl_wr=1, ioctl_index=254 and ioctl_addr[24:3]=0, then byte ioctl_addr[2:0] of dip_sw <= ioctl_dout; other addresses are ignored.
REQ-031 Mod capture, in any state: if ioctl_wr=1 and ioctl_index=1, then mod_byte <= ioctl_dout and mod_valid <= 1; the last write wins.
REQ-032 If ioctl_index changes away from 0 during LOAD, nothing further is routed; the FSM still exits only on ioctl_download=0.

Reset
REQ-033 Reset returns the FSM to IDLE and clears rom_wr, rom_addr, rom_data, region_ok, load_done, mod_byte, mod_valid and all counters.
REQ-034 dip_sw is also cleared by reset.
REQ-035 Reset asserted during LOAD aborts the download: no load_done pulse, and region_ok stays 0.

Configuration
REQ-036 Macro ROM_LOAD_ROUTER_CHECKSUM_EN defined: add output rom_sum [15:0], the modulo-2^16 sum of all routed bytes.
REQ-037 With the macro defined, rom_sum is cleared on LOAD entry and on reset, updates one cycle after each routed byte, and holds after DONE.
REQ-038 Macro undefined: the rom_sum port and its logic are absent; all other behaviour is identical.

Verification
REQ-039 Defaults; index 0; write bytes at 0x0000..0x7FFF, 0xE000..0xEFFF and 0xFF00..0x1FEFF; drop download -> load_done pulses once and region_ok=3'b111.
REQ-040 Write 0xA5 at addr 0xE123 -> next cycle rom_wr=3'b010, rom_addr=0x0123, rom_data=0xA5.
REQ-041 Write to 0x9000 -> rom_wr=0 and all counters unchanged; region 0 short by one byte -> region_ok[0]=0.
REQ-042 Index 254, addr 2, data 0x3C -> dip_sw[23:16]=0x3C; addr 8 -> dip_sw unchanged; index 1, data 0x04 -> mod_byte=0x04, mod_valid=1.
REQ-043 Reset pulsed mid-LOAD -> state IDLE, no load_done, region_ok=0; a new download then completes normally.
REQ-044 With the checksum macro defined: route bytes 0xFF, 0x02, 0x01 -> rom_sum=0x0102.
